flash_cmd_sequencer: RTL

FLASH_CMD_SEQUENCER -- requirements
Module: flash_cmd_sequencer

---
 rtl/flash_cmd_sequencer_if.sv | 48 ++++
 rtl/flash_cmd_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// FlashCmdSequencerIf
// Bundles the command handshake, CPU arbitration input and the parallel NOR
// flash bus used by flash_cmd_sequencer.
//
// Ports / members:
//   cmd_valid, cmd_op[1:0], cmd_addr[26:0], cmd_data[7:0]   command request
//   cmd_ready                                                 IDLE indicator
//   cpu_rom_access                                            CPU owns flash bus
//   flash_addr[26:0], flash_dout[7:0], flash_din[7:0]         flash data/addr
//   flash_ce_n, flash_oe_n, flash_we_n                        active-low strobes
//   flash_dout_en                                             write-data drive
//   busy, done, error                                         status
//
// Modports:
//   slave  - the sequencer itself
//   master - the command issuer / environment (CPU side plus flash device)
// ---------------------------------------------------------------------------
interface flash_cmd_sequencer_if;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [26:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        cpu_rom_access;
    logic [26:0] flash_addr;
    logic [7:0]  flash_dout;
    logic [7:0]  flash_din;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic        flash_dout_en;
    logic        busy;
    logic        done;
    logic        error;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cpu_rom_access, flash_din,
        output cmd_ready, flash_addr, flash_dout, flash_ce_n, flash_oe_n,
               flash_we_n, flash_dout_en, busy, done, error
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cpu_rom_access, flash_din,
        input  cmd_ready, flash_addr, flash_dout, flash_ce_n, flash_oe_n,
               flash_we_n, flash_dout_en, busy, done, error
    );
endinterface

// File: rtl/flash_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// flash_cmd_sequencer
// Issues AMD/JEDEC-style NOR flash command sequences (program byte, sector
// erase, chip erase, reset/F0) and polls the device with the DQ6 toggle bit
// until the embedded operation finishes or the poll budget runs out.
//
// Ports:
//   m2     - clock, all state changes on its rising edge
//   reset  - asynchronous, active-high reset
//   bus    - flash_cmd_sequencer_if.slave (command handshake + flash bus)
//
// Parameters:
//   TIMEOUT_W - width of the poll-pair counter; a toggling poll gives up
//               after 2^TIMEOUT_W-1 pairs.
//
// Build option:
//   FLASH_SEQ_DQ5_ABORT_EN - when defined, a toggling poll pair with DQ5=1
//   in the second read is treated as a device failure and aborted at once.
// ---------------------------------------------------------------------------
module flash_cmd_sequencer #(
    parameter int TIMEOUT_W = 20
) (
    input logic               m2,
    input logic               reset,
    flash_cmd_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, ARB, WR_SETUP, WR_PULSE, WR_HOLD, RD_A, RD_B, FINISH
    } seqState_t;

    localparam logic [1:0]  OP_PROG  = 2'b00;
    localparam logic [1:0]  OP_SECT  = 2'b01;
    localparam logic [1:0]  OP_CHIP  = 2'b10;
    localparam logic [1:0]  OP_RST   = 2'b11;
    localparam logic [26:0] ADDR_AAA = 27'h0000AAA;
    localparam logic [26:0] ADDR_555 = 27'h0000555;

    seqState_t              state_q;
    logic [1:0]             op_q;
    logic [26:0]            cmdAddr_q;
    logic [7:0]             cmdData_q;
    logic [2:0]             step_q;
    logic [TIMEOUT_W-1:0]   tmo_q;
    logic                   sampleDq6_q;
    logic                   pollNext_q;
    logic                   f0Pending_q;
    logic                   error_q;
    logic                   done_q;
    logic                   ceN_q;
    logic                   oeN_q;
    logic                   weN_q;
    logic                   doutEn_q;
    logic [26:0]            flashAddr_q;
    logic [7:0]             flashDout_q;

    logic [26:0]            pairAddr;
    logic [7:0]             pairData;
    logic [2:0]             lastStep;
    logic [TIMEOUT_W-1:0]   tmo_d;
    logic                   tmoWrap;
    logic                   dq5Abort;

    // Address/data pair for the current step. A pending recovery reset
    // overrides the normal table so the F0 write reuses the same bus cycle.
    always_comb begin
        pairAddr = cmdAddr_q;
        pairData = 8'hF0;
        lastStep = 3'd0;
        if (!f0Pending_q) begin
            case (op_q)
                OP_PROG: begin
                    lastStep = 3'd3;
                    case (step_q)
                        3'd0:    begin pairAddr = ADDR_AAA;  pairData = 8'hAA;     end
                        3'd1:    begin pairAddr = ADDR_555;  pairData = 8'h55;     end
                        3'd2:    begin pairAddr = ADDR_AAA;  pairData = 8'hA0;     end
                        default: begin pairAddr = cmdAddr_q; pairData = cmdData_q; end
                    endcase
                end
                OP_SECT, OP_CHIP: begin
                    lastStep = 3'd5;
                    case (step_q)
                        3'd0, 3'd3: begin pairAddr = ADDR_AAA; pairData = 8'hAA; end
                        3'd1, 3'd4: begin pairAddr = ADDR_555; pairData = 8'h55; end
                        3'd2:       begin pairAddr = ADDR_AAA; pairData = 8'h80; end
                        default: begin
                            if (op_q == OP_SECT) begin
                                pairAddr = cmdAddr_q;
                                pairData = 8'h30;
                            end else begin
                                pairAddr = ADDR_AAA;
                                pairData = 8'h10;
                            end
                        end
                    endcase
                end
                default: begin
                    pairAddr = cmdAddr_q;
                    pairData = 8'hF0;
                end
            endcase
        end
    end

    // The poll budget is exhausted once the incremented count reaches all ones.
    assign tmo_d   = tmo_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    assign tmoWrap = &tmo_d;

`ifdef FLASH_SEQ_DQ5_ABORT_EN
    assign dq5Abort = bus.flash_din[5];
`else
    assign dq5Abort = 1'b0;
`endif

    // Main sequencer: every bus strobe is registered and updated on the same
    // edge that enters the state it belongs to, so the flash sees clean,
    // glitch-free strobes aligned with the state register.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_PROG;
            cmdAddr_q   <= '0;
            cmdData_q   <= '0;
            step_q      <= '0;
            tmo_q       <= '0;
            sampleDq6_q <= 1'b0;
            pollNext_q  <= 1'b0;
            f0Pending_q <= 1'b0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            ceN_q       <= 1'b1;
            oeN_q       <= 1'b1;
            weN_q       <= 1'b1;
            doutEn_q    <= 1'b0;
            flashAddr_q <= '0;
            flashDout_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q        <= bus.cmd_op;
                        cmdAddr_q   <= bus.cmd_addr;
                        cmdData_q   <= bus.cmd_data;
                        error_q     <= 1'b0;
                        step_q      <= '0;
                        tmo_q       <= '0;
                        pollNext_q  <= 1'b0;
                        f0Pending_q <= 1'b0;
                        state_q     <= ARB;
                    end
                end
                ARB: begin
                    // The CPU is only given priority between bus cycles.
                    if (!bus.cpu_rom_access) begin
                        ceN_q <= 1'b0;
                        if (pollNext_q) begin
                            oeN_q       <= 1'b0;
                            doutEn_q    <= 1'b0;
                            flashAddr_q <= cmdAddr_q;
                            state_q     <= RD_A;
                        end else begin
                            doutEn_q    <= 1'b1;
                            flashAddr_q <= pairAddr;
                            flashDout_q <= pairData;
                            state_q     <= WR_SETUP;
                        end
                    end
                end
                WR_SETUP: begin
                    weN_q   <= 1'b0;
                    state_q <= WR_PULSE;
                end
                WR_PULSE: begin
                    weN_q   <= 1'b1;
                    ceN_q   <= 1'b1;
                    state_q <= WR_HOLD;
                end
                WR_HOLD: begin
                    doutEn_q <= 1'b0;
                    if (f0Pending_q || (op_q == OP_RST)) begin
                        f0Pending_q <= 1'b0;
                        done_q      <= ~error_q;
                        state_q     <= FINISH;
                    end else if (step_q != lastStep) begin
                        step_q  <= step_q + 3'd1;
                        state_q <= ARB;
                    end else begin
                        pollNext_q <= 1'b1;
                        state_q    <= ARB;
                    end
                end
                RD_A: begin
                    sampleDq6_q <= bus.flash_din[6];
                    state_q     <= RD_B;
                end
                RD_B: begin
                    ceN_q <= 1'b1;
                    oeN_q <= 1'b1;
                    if (bus.flash_din[6] == sampleDq6_q) begin
                        done_q  <= ~error_q;
                        state_q <= FINISH;
                    end else if (dq5Abort || tmoWrap) begin
                        // Device failed or never settled: recover it with F0.
                        tmo_q       <= tmo_d;
                        error_q     <= 1'b1;
                        f0Pending_q <= 1'b1;
                        pollNext_q  <= 1'b0;
                        state_q     <= ARB;
                    end else begin
                        tmo_q   <= tmo_d;
                        state_q <= ARB;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.flash_ce_n    = ceN_q;
    assign bus.flash_oe_n    = oeN_q;
    assign bus.flash_we_n    = weN_q;
    assign bus.flash_dout_en = doutEn_q;
    assign bus.flash_addr    = flashAddr_q;
    assign bus.flash_dout    = flashDout_q;

endmodule
